// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-ported, multi-cycle SRAM between the instruction-fetch
// (IF) stage and the load/store (MEM) stage. Each transfer takes WAIT_CYCLES
// cycles with the address/data held stable. It is followed by a one-cycle
// ready pulse to the requester that was served. Simultaneous requests are
// arbitrated round-robin.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_req/if_addr      fetch request and byte address
//   if_rdata/if_ready   fetched word, one-cycle completion pulse
//   if_freeze           fetch stage must hold (request not yet completed)
//   mem_rd_req/mem_wr_req/mem_addr/mem_wdata   load/store request
//   mem_rdata/mem_ready load data, one-cycle completion pulse
//   mem_freeze          memory stage must hold
//   sram_addr/sram_wdata/sram_we_n/sram_oe_n/sram_rdata   SRAM pins
module sram_port_arbiter #(
   parameter int ADDRESS_LEN = 32,
   parameter int DATA_LEN    = 32,
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_req,
   input  logic [ADDRESS_LEN-1:0] if_addr,
   output logic [DATA_LEN-1:0]    if_rdata,
   output logic                   if_ready,
   output logic                   if_freeze,
   input  logic                   mem_rd_req,
   input  logic                   mem_wr_req,
   input  logic [ADDRESS_LEN-1:0] mem_addr,
   input  logic [DATA_LEN-1:0]    mem_wdata,
   output logic [DATA_LEN-1:0]    mem_rdata,
   output logic                   mem_ready,
   output logic                   mem_freeze,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_LEN-1:0]    sram_wdata,
   output logic                   sram_we_n,
   output logic                   sram_oe_n,
   input  logic [DATA_LEN-1:0]    sram_rdata
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // Requester encoding for grant_reg / last_grant_reg: 0 = IF, 1 = MEM.
   localparam logic GRANT_IF  = 1'b0;
   localparam logic GRANT_MEM = 1'b1;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   last_grant_reg, last_grant_next;
   logic                   grant_reg, grant_next;
   logic                   write_reg, write_next;
   logic [SRAM_ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_LEN-1:0]    wdata_reg, wdata_next;
   logic [DATA_LEN-1:0]    if_rdata_reg, if_rdata_next;
   logic [DATA_LEN-1:0]    mem_rdata_reg, mem_rdata_next;

   logic if_pending;
   logic mem_pending;
   logic pick_mem;

   // Byte-offset bits and bits above the SRAM range are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[ADDRESS_LEN-1:SRAM_ADDR_W+2], if_addr[1:0],
                               mem_addr[ADDRESS_LEN-1:SRAM_ADDR_W+2], mem_addr[1:0]};

   assign if_pending  = if_req;
   assign mem_pending = mem_rd_req | mem_wr_req;

   // MEM wins when alone, or on a tie when IF was served last.
   assign pick_mem = mem_pending & (~if_pending | (last_grant_reg == GRANT_IF));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= GRANT_IF;
         grant_reg      <= GRANT_IF;
         write_reg      <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         if_rdata_reg   <= '0;
         mem_rdata_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         last_grant_reg <= last_grant_next;
         grant_reg      <= grant_next;
         write_reg      <= write_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         if_rdata_reg   <= if_rdata_next;
         mem_rdata_reg  <= mem_rdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      last_grant_next = last_grant_reg;
      grant_next      = grant_reg;
      write_next      = write_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      if_rdata_next   = if_rdata_reg;
      mem_rdata_next  = mem_rdata_reg;

      case (state_reg)
         IDLE: begin
            if (if_pending || mem_pending) begin
               state_next = ACCESS;
               cnt_next   = '0;
               if (pick_mem) begin
                  grant_next = GRANT_MEM;
                  addr_next  = mem_addr[SRAM_ADDR_W+1:2];
                  // A simultaneous read+write request is executed as a write.
                  write_next = mem_wr_req;
                  wdata_next = mem_wdata;
               end else begin
                  grant_next = GRANT_IF;
                  addr_next  = if_addr[SRAM_ADDR_W+1:2];
                  write_next = 1'b0;
               end
            end
         end

         ACCESS: begin
            if (cnt_reg == CNT_LAST) begin
               if (!write_reg) begin
                  if (grant_reg == GRANT_MEM) begin
                     mem_rdata_next = sram_rdata;
                  end else begin
                     if_rdata_next = sram_rdata;
                  end
               end
               state_next      = DONE;
               last_grant_next = grant_reg;
               cnt_next        = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Strobes decode from the registered state, so an asynchronous reset
   // releases sram_we_n in the same instant it aborts the access.
   assign sram_we_n = ~((state_reg == ACCESS) & write_reg);
   assign sram_oe_n = ~((state_reg == ACCESS) & ~write_reg);
   assign sram_addr  = addr_reg;
   assign sram_wdata = wdata_reg;

   assign if_ready  = (state_reg == DONE) & (grant_reg == GRANT_IF);
   assign mem_ready = (state_reg == DONE) & (grant_reg == GRANT_MEM);
   assign if_rdata  = if_rdata_reg;
   assign mem_rdata = mem_rdata_reg;

   assign if_freeze  = if_req & ~if_ready;
   assign mem_freeze = (mem_rd_req | mem_wr_req) & ~mem_ready;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter. A default instance
// (WAIT_CYCLES=3) covers reset, reads, writes, arbitration and reset abort;
// a second instance (WAIT_CYCLES=1) covers back-to-back single-cycle access.
module tb_sram_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        if_freeze;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_freeze;
   logic [17:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_we_n;
   logic        sram_oe_n;
   logic [31:0] sram_rdata;

   logic        b_rst;
   logic        b_if_req;
   logic [31:0] b_if_addr;
   logic [31:0] b_if_rdata;
   logic        b_if_ready;
   logic        b_if_freeze;
   logic        b_mem_rd_req;
   logic        b_mem_wr_req;
   logic [31:0] b_mem_addr;
   logic [31:0] b_mem_wdata;
   logic [31:0] b_mem_rdata;
   logic        b_mem_ready;
   logic        b_mem_freeze;
   logic [17:0] b_sram_addr;
   logic [31:0] b_sram_wdata;
   logic        b_sram_we_n;
   logic        b_sram_oe_n;
   logic [31:0] b_sram_rdata;

   int n_checks;
   int n_fail;

   sram_port_arbiter #(
      .ADDRESS_LEN(32), .DATA_LEN(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(3)
   ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .if_freeze(if_freeze),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_freeze(mem_freeze),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
      .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata)
   );

   sram_port_arbiter #(
      .ADDRESS_LEN(32), .DATA_LEN(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)
   ) u_dut_w1 (
      .clk(clk), .rst(b_rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
      .if_ready(b_if_ready), .if_freeze(b_if_freeze),
      .mem_rd_req(b_mem_rd_req), .mem_wr_req(b_mem_wr_req), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
      .mem_freeze(b_mem_freeze),
      .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_we_n(b_sram_we_n),
      .sram_oe_n(b_sram_oe_n), .sram_rdata(b_sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0; b_rst = 1'b0;
      if_req = 1'b0; if_addr = '0; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
      mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
      b_if_req = 1'b0; b_if_addr = '0; b_mem_rd_req = 1'b0; b_mem_wr_req = 1'b0;
      b_mem_addr = '0; b_mem_wdata = '0; b_sram_rdata = '0;

      // Reset state
      tick();
      check_val("rst_if_ready", {31'b0, if_ready}, 32'd0);
      check_val("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
      check_val("rst_if_rdata", if_rdata, 32'd0);
      check_val("rst_mem_rdata", mem_rdata, 32'd0);
      check_val("rst_sram_addr", {14'b0, sram_addr}, 32'd0);
      check_val("rst_sram_wdata", sram_wdata, 32'd0);
      check_val("rst_we_n", {31'b0, sram_we_n}, 32'd1);
      check_val("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
      tick();
      rst = 1'b1;

      // IF read at byte 0x100 -> word 0x40
      if_req = 1'b1; if_addr = 32'h100; sram_rdata = 32'hE3A01005;
      #1;
      check_val("rd_freeze_t0", {31'b0, if_freeze}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("rd_addr", {14'b0, sram_addr}, 32'h40);
         check_val("rd_oe_n", {31'b0, sram_oe_n}, 32'd0);
         check_val("rd_we_n", {31'b0, sram_we_n}, 32'd1);
         check_val("rd_if_ready_early", {31'b0, if_ready}, 32'd0);
         check_val("rd_freeze", {31'b0, if_freeze}, 32'd1);
      end
      tick();
      check_val("rd_if_ready", {31'b0, if_ready}, 32'd1);
      check_val("rd_if_rdata", if_rdata, 32'hE3A01005);
      check_val("rd_freeze_done", {31'b0, if_freeze}, 32'd0);
      check_val("rd_oe_n_done", {31'b0, sram_oe_n}, 32'd1);
      $display("txn IF read addr=0x100 rdata=0x%08h", if_rdata);
      if_req = 1'b0;
      tick();
      check_val("rd_if_ready_after", {31'b0, if_ready}, 32'd0);

      // MEM store 0xDEADBEEF at byte 0x8 -> word 0x2
      mem_wr_req = 1'b1; mem_addr = 32'h8; mem_wdata = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("wr_we_n", {31'b0, sram_we_n}, 32'd0);
         check_val("wr_oe_n", {31'b0, sram_oe_n}, 32'd1);
         check_val("wr_addr", {14'b0, sram_addr}, 32'h2);
         check_val("wr_wdata", sram_wdata, 32'hDEADBEEF);
         check_val("wr_ready_early", {31'b0, mem_ready}, 32'd0);
      end
      tick();
      check_val("wr_mem_ready", {31'b0, mem_ready}, 32'd1);
      check_val("wr_we_n_done", {31'b0, sram_we_n}, 32'd1);
      check_val("wr_mem_rdata", mem_rdata, 32'd0);
      $display("txn MEM write addr=0x8 wdata=0xdeadbeef");
      mem_wr_req = 1'b0;
      tick();
      check_val("wr_ready_after", {31'b0, mem_ready}, 32'd0);

      // MEM load sets mem_rdata, then a read+write request must leave it intact
      mem_rd_req = 1'b1; mem_addr = 32'h40; sram_rdata = 32'h12345678;
      for (int i = 0; i < 4; i++) tick();
      check_val("ld_mem_ready", {31'b0, mem_ready}, 32'd1);
      check_val("ld_mem_rdata", mem_rdata, 32'h12345678);
      $display("txn MEM read addr=0x40 rdata=0x%08h", mem_rdata);
      mem_rd_req = 1'b0;
      tick();
      mem_rd_req = 1'b1; mem_wr_req = 1'b1; mem_wdata = 32'hCAFEF00D; sram_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("rw_we_n", {31'b0, sram_we_n}, 32'd0);
         check_val("rw_oe_n", {31'b0, sram_oe_n}, 32'd1);
         check_val("rw_wdata", sram_wdata, 32'hCAFEF00D);
      end
      tick();
      check_val("rw_mem_ready", {31'b0, mem_ready}, 32'd1);
      check_val("rw_mem_rdata", mem_rdata, 32'h12345678);
      $display("txn MEM read+write addr=0x40 wdata=0xcafef00d");
      mem_rd_req = 1'b0; mem_wr_req = 1'b0;
      tick();

      // Round-robin: both requests held from reset release
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h10; mem_rd_req = 1'b1; mem_addr = 32'h20;
      tick();
      rst = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         check_val("rr_mem_ready", {31'b0, mem_ready}, (n == 4 || n == 14) ? 32'd1 : 32'd0);
         check_val("rr_if_ready", {31'b0, if_ready}, (n == 9 || n == 19) ? 32'd1 : 32'd0);
         if (mem_ready) $display("txn RR grant MEM ready at cycle %0d", n);
         if (if_ready)  $display("txn RR grant IF ready at cycle %0d", n);
      end
      if_req = 1'b0; mem_rd_req = 1'b0;
      tick();

      // Reset during the second ACCESS cycle of a write
      mem_wr_req = 1'b1; mem_addr = 32'h8; mem_wdata = 32'h11112222;
      tick();
      check_val("ab_we_n_c0", {31'b0, sram_we_n}, 32'd0);
      tick();
      check_val("ab_we_n_c1", {31'b0, sram_we_n}, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      check_val("ab_we_n_rst", {31'b0, sram_we_n}, 32'd1);
      check_val("ab_mem_ready_rst", {31'b0, mem_ready}, 32'd0);
      check_val("ab_sram_addr_rst", {14'b0, sram_addr}, 32'd0);
      mem_wr_req = 1'b0; if_req = 1'b1; if_addr = 32'h200; sram_rdata = 32'h0BADF00D;
      tick();
      rst = 1'b1;
      #1;
      check_val("ab_idle_oe_n", {31'b0, sram_oe_n}, 32'd1);
      for (int n = 1; n <= 4; n++) begin
         tick();
         check_val("ab_mem_ready", {31'b0, mem_ready}, 32'd0);
         check_val("ab_if_ready", {31'b0, if_ready}, (n == 4) ? 32'd1 : 32'd0);
      end
      check_val("ab_if_rdata", if_rdata, 32'h0BADF00D);
      check_val("ab_mem_rdata_reset", mem_rdata, 32'd0);
      $display("txn IF read after abort rdata=0x%08h", if_rdata);
      if_req = 1'b0;
      tick();

      // WAIT_CYCLES=1 instance: back-to-back IF reads, ready every 3 cycles
      b_if_req = 1'b1; b_if_addr = 32'h30; b_sram_rdata = 32'h55AA55AA;
      b_rst = 1'b1;
      #1;
      check_val("w1_oe_n_idle", {31'b0, b_sram_oe_n}, 32'd1);
      for (int n = 1; n <= 9; n++) begin
         tick();
         check_val("w1_if_ready", {31'b0, b_if_ready}, ((n % 3) == 2) ? 32'd1 : 32'd0);
         check_val("w1_oe_n", {31'b0, b_sram_oe_n}, ((n % 3) == 1) ? 32'd0 : 32'd1);
         check_val("w1_addr", {14'b0, b_sram_addr}, 32'hC);
         if ((n % 3) == 2) begin
            check_val("w1_if_rdata", b_if_rdata, 32'h55AA55AA);
            $display("txn W1 IF read ready at cycle %0d rdata=0x%08h", n, b_if_rdata);
         end
      end
      b_if_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
